// File: rtl/ucode_checkpoint_monitor_if.sv
// Bundle of the checkpoint monitor's configuration, retire-stream and result signals.
// Latency: none (wiring only); the monitor registers every result it drives.
// Backpressure: none; result pulses are single-cycle and must be consumed when seen.
interface ucode_checkpoint_monitor_if #(
  parameter int PC_W    = 12,
  parameter int ENTRIES = 16,
  parameter int FAILS   = 4,
  parameter int CNT_W   = 16,
  parameter int LIMIT_W = 32
);
  // control and table loading
  logic                       start;
  logic                       cfg_we;
  logic [$clog2(ENTRIES)-1:0] cfg_idx;
  logic [1:0]                 cfg_kind;
  logic [PC_W-1:0]            cfg_from;
  logic [PC_W-1:0]            cfg_to;
  logic [PC_W-1:0]            cfg_target;
  logic                       fail_we;
  logic [$clog2(FAILS)-1:0]   fail_idx;
  logic [PC_W-1:0]            fail_addr;
  logic [LIMIT_W-1:0]         limit;
  // retire stream from the core
  logic                       retire;
  logic [PC_W-1:0]            pc_x;
  logic [PC_W-1:0]            pc_f;
  logic                       cont_pe;
  logic [PC_W-1:0]            cont_addr;
  // results
  logic                       redirect_valid;
  logic [PC_W-1:0]            redirect_addr;
  logic                       pass_valid;
  logic [$clog2(ENTRIES)-1:0] pass_idx;
  logic [ENTRIES-1:0]         hits;
  logic [CNT_W-1:0]           pass_count;
  logic [2:0]                 status;
  logic                       done;

  // Driver side: test harness / core wrapper
  modport master (
    output start, cfg_we, cfg_idx, cfg_kind, cfg_from, cfg_to, cfg_target,
    output fail_we, fail_idx, fail_addr, limit,
    output retire, pc_x, pc_f, cont_pe, cont_addr,
    input  redirect_valid, redirect_addr, pass_valid, pass_idx,
    input  hits, pass_count, status, done
  );

  // Monitor side
  modport slave (
    input  start, cfg_we, cfg_idx, cfg_kind, cfg_from, cfg_to, cfg_target,
    input  fail_we, fail_idx, fail_addr, limit,
    input  retire, pc_x, pc_f, cont_pe, cont_addr,
    output redirect_valid, redirect_addr, pass_valid, pass_idx,
    output hits, pass_count, status, done
  );
endinterface

// File: rtl/ucode_checkpoint_monitor.sv
// Microcode self-test checkpoint monitor: pass/skip/end/fail table plus optional watchdog (UCODE_MON_WATCHDOG_EN).
// Latency: every result is registered, visible one cycle after the retire that caused it.
// Backpressure: none; redirect/pass pulses last one cycle, table writes are dropped while running.
module ucode_checkpoint_monitor #(
  parameter int PC_W    = 12,
  parameter int ENTRIES = 16,
  parameter int FAILS   = 4,
  parameter int CNT_W   = 16,
  parameter int LIMIT_W = 32
) (
  input logic                        clk,
  input logic                        reset,
  ucode_checkpoint_monitor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [1:0] K_OFF  = 2'd0;
  localparam logic [1:0] K_PASS = 2'd1;
  localparam logic [1:0] K_SKIP = 2'd2;
  localparam logic [1:0] K_END  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // checkpoint table and fail labels
  logic [1:0]      kind_q   [ENTRIES];
  logic [PC_W-1:0] from_q   [ENTRIES];
  logic [PC_W-1:0] to_q     [ENTRIES];
  logic [PC_W-1:0] target_q [ENTRIES];
  logic [FAILS-1:0] fail_vld_q;
  logic [PC_W-1:0]  fail_addr_q [FAILS];

  // run state and registered outputs
  logic [2:0]         state_q, state_d;
  logic               done_q, done_d;
  logic [ENTRIES-1:0] hits_q, hits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rv_q, rv_d;
  logic [PC_W-1:0]    raddr_q, raddr_d;
  logic               pv_q, pv_d;
  logic [IDX_W-1:0]   pidx_q, pidx_d;

  // match results
  logic               fail_hit;
  logic               end_hit;
  logic               skip_hit;
  logic [PC_W-1:0]    skip_tgt;
  logic [ENTRIES-1:0] pass_match;
  logic [ENTRIES-1:0] new_hits;
  logic [IDX_W-1:0]   first_idx;
  logic [CNT_W-1:0]   cnt_sat;
  logic               wdog_fire;
  logic               cfg_ok;

  // The table is frozen while a run is in progress so matches stay stable.
  assign cfg_ok = (state_q != ST_RUN);

  // Table and fail-slot storage; reset wipes the whole table.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        kind_q[i]   <= K_OFF;
        from_q[i]   <= '0;
        to_q[i]     <= '0;
        target_q[i] <= '0;
      end
      fail_vld_q <= '0;
      for (int f = 0; f < FAILS; f++) begin
        fail_addr_q[f] <= '0;
      end
    end else begin
      if (cfg_ok && bus.cfg_we) begin
        kind_q[bus.cfg_idx]   <= bus.cfg_kind;
        from_q[bus.cfg_idx]   <= bus.cfg_from;
        to_q[bus.cfg_idx]     <= bus.cfg_to;
        target_q[bus.cfg_idx] <= bus.cfg_target;
      end
      if (cfg_ok && bus.fail_we) begin
        fail_vld_q[bus.fail_idx]  <= 1'b1;
        fail_addr_q[bus.fail_idx] <= bus.fail_addr;
      end
    end
  end

  // Compare the retiring instruction against every fail slot and table entry.
  always_comb begin
    fail_hit   = 1'b0;
    end_hit    = 1'b0;
    skip_hit   = 1'b0;
    skip_tgt   = '0;
    pass_match = '0;
    for (int f = 0; f < FAILS; f++) begin
      if (fail_vld_q[f] && (fail_addr_q[f] == bus.pc_x)) fail_hit = 1'b1;
    end
    // descending scan so the lowest matching skip entry is the one left standing
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if ((kind_q[i] == K_END) && (from_q[i] == bus.pc_x)) end_hit = 1'b1;
      if ((kind_q[i] == K_SKIP) && (from_q[i] == bus.pc_x) && (to_q[i] == bus.pc_f)) begin
        skip_hit = 1'b1;
        skip_tgt = target_q[i];
      end
      pass_match[i] = (kind_q[i] == K_PASS) && bus.cont_pe && (bus.cont_addr == from_q[i]);
    end
  end

  assign new_hits = pass_match & ~hits_q;

  // Lowest newly hit entry and the saturating count of newly hit entries.
  always_comb begin
    first_idx = '0;
    cnt_sat   = cnt_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (new_hits[i]) first_idx = IDX_W'(i);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (new_hits[i] && (cnt_sat != {CNT_W{1'b1}})) cnt_sat = cnt_sat + CNT_ONE;
    end
  end

`ifdef UCODE_MON_WATCHDOG_EN
  localparam logic [LIMIT_W-1:0] LIMIT_ONE = {{(LIMIT_W-1){1'b0}}, 1'b1};
  logic [LIMIT_W-1:0] wdog_q, wdog_d;

  assign wdog_fire = (bus.limit != '0) && (wdog_q == bus.limit - LIMIT_ONE);

  // Watchdog counts every cycle spent in RUN, restarting from zero on arm.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_RUN) begin
      wdog_d = wdog_q + LIMIT_ONE;
    end else if (bus.start) begin
      wdog_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unused_limit;
  assign unused_limit = ^bus.limit;
  assign wdog_fire    = 1'b0;
`endif

  // Run-state sequencing and event selection for each retire.
  always_comb begin
    state_d = state_q;
    hits_d  = hits_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    raddr_d = raddr_q;
    pv_d    = 1'b0;
    pidx_d  = pidx_q;
    if (state_q == ST_RUN) begin
      if (bus.retire) begin
        if (fail_hit) begin
          state_d = ST_FAIL;
        end else if (end_hit) begin
          state_d = ST_PASS;
        end else begin
          // a retire right after a redirect still carries the pre-jump pc_f
          if (skip_hit && !rv_q) begin
            rv_d    = 1'b1;
            raddr_d = skip_tgt;
          end
          if (|new_hits) begin
            hits_d = hits_q | new_hits;
            pv_d   = 1'b1;
            pidx_d = first_idx;
            cnt_d  = cnt_sat;
          end
        end
      end
      if ((state_d == ST_RUN) && wdog_fire) state_d = ST_TIMEOUT;
    end else if (bus.start) begin
      state_d = ST_RUN;
      hits_d  = '0;
      cnt_d   = '0;
    end
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
  end

  // Registered run state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      hits_q  <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      raddr_q <= '0;
      pv_q    <= 1'b0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      hits_q  <= hits_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      raddr_q <= raddr_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
    end
  end

  assign bus.redirect_valid = rv_q;
  assign bus.redirect_addr  = raddr_q;
  assign bus.pass_valid     = pv_q;
  assign bus.pass_idx       = pidx_q;
  assign bus.hits           = hits_q;
  assign bus.pass_count     = cnt_q;
  assign bus.status         = state_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_ucode_checkpoint_monitor.sv
// Self-checking bench for ucode_checkpoint_monitor: vector table through a scoreboard queue plus corner sequences.
// Latency: expects results one cycle after each driven retire.
// Backpressure: none; pulses are sampled in the single cycle they are valid.
module tb_ucode_checkpoint_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ucode_checkpoint_monitor_if #(.PC_W(12), .ENTRIES(16), .FAILS(4), .CNT_W(16), .LIMIT_W(32)) bus ();

  ucode_checkpoint_monitor #(.PC_W(12), .ENTRIES(16), .FAILS(4), .CNT_W(16), .LIMIT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        retire;
    logic [11:0] pc_x;
    logic [11:0] pc_f;
    logic        cont_pe;
    logic [11:0] cont_addr;
    logic        rv;
    logic [11:0] raddr;
    logic        pv;
    logic [3:0]  pidx;
    logic [15:0] hits;
    logic [15:0] cnt;
    logic [2:0]  st;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];
  vec_t sb_q [$];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [1:0] kind,
                           input logic [11:0] from, input logic [11:0] to, input logic [11:0] tgt);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_kind = kind;
    bus.cfg_from = from; bus.cfg_to = to; bus.cfg_target = tgt;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic fail_write(input logic [1:0] idx, input logic [11:0] addr);
    bus.fail_we = 1'b1; bus.fail_idx = idx; bus.fail_addr = addr;
    tick();
    bus.fail_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_retire(input logic [11:0] pcx, input logic [11:0] pcf,
                           input logic pe, input logic [11:0] ca);
    bus.retire = 1'b1; bus.pc_x = pcx; bus.pc_f = pcf; bus.cont_pe = pe; bus.cont_addr = ca;
    tick();
    bus.retire = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 0; bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_kind = 0;
    bus.cfg_from = 0; bus.cfg_to = 0; bus.cfg_target = 0;
    bus.fail_we = 0; bus.fail_idx = 0; bus.fail_addr = 0; bus.limit = 0;
    bus.retire = 0; bus.pc_x = 0; bus.pc_f = 0; bus.cont_pe = 0; bus.cont_addr = 0;

    // retire pcx pcf pe ca | rv raddr pv pidx hits cnt status
    vec[0]  = '{1'b1, 12'd0,    12'd1, 1'b0, 12'd0,  1'b1, 12'd8, 1'b0, 4'd0,  16'h0000, 16'd0, 3'd1};
    vec[1]  = '{1'b1, 12'd0,    12'd1, 1'b0, 12'd0,  1'b0, 12'd0, 1'b0, 4'd0,  16'h0000, 16'd0, 3'd1};
    vec[2]  = '{1'b1, 12'd0,    12'd1, 1'b0, 12'd0,  1'b1, 12'd8, 1'b0, 4'd0,  16'h0000, 16'd0, 3'd1};
    vec[3]  = '{1'b0, 12'd0,    12'd1, 1'b0, 12'd0,  1'b0, 12'd0, 1'b0, 4'd0,  16'h0000, 16'd0, 3'd1};
    vec[4]  = '{1'b1, 12'd3,    12'd4, 1'b1, 12'd12, 1'b0, 12'd0, 1'b1, 4'd2,  16'h0024, 16'd2, 3'd1};
    vec[5]  = '{1'b1, 12'd3,    12'd4, 1'b1, 12'd12, 1'b0, 12'd0, 1'b0, 4'd0,  16'h0024, 16'd2, 3'd1};
    vec[6]  = '{1'b1, 12'd0,    12'd1, 1'b1, 12'd30, 1'b1, 12'd8, 1'b1, 4'd11, 16'h0824, 16'd3, 3'd1};
    vec[7]  = '{1'b1, 12'd5,    12'd6, 1'b0, 12'd30, 1'b0, 12'd0, 1'b0, 4'd0,  16'h0824, 16'd3, 3'd1};
    vec[8]  = '{1'b1, 12'd6,    12'd7, 1'b1, 12'd20, 1'b0, 12'd0, 1'b0, 4'd0,  16'h0824, 16'd3, 3'd1};
    vec[9]  = '{1'b1, 12'd1564, 12'd0, 1'b0, 12'd0,  1'b0, 12'd0, 1'b0, 4'd0,  16'h0824, 16'd3, 3'd2};
    vec[10] = '{1'b1, 12'd0,    12'd1, 1'b1, 12'd12, 1'b0, 12'd0, 1'b0, 4'd0,  16'h0824, 16'd3, 3'd2};

    // reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hits", 32'(bus.hits), 32'd0);
    chk("rst_count", 32'(bus.pass_count), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("rst_pass", 32'(bus.pass_valid), 32'd0);

    // table load in IDLE
    cfg_write(4'd0,  2'd2, 12'd0,    12'd1, 12'd8);
    cfg_write(4'd2,  2'd1, 12'd12,   12'd0, 12'd0);
    cfg_write(4'd5,  2'd1, 12'd12,   12'd0, 12'd0);
    cfg_write(4'd7,  2'd3, 12'd1564, 12'd0, 12'd0);
    cfg_write(4'd8,  2'd3, 12'd1666, 12'd0, 12'd0);
    cfg_write(4'd11, 2'd1, 12'd30,   12'd0, 12'd0);
    fail_write(2'd0, 12'd1666);
    pulse_start();
    chk("start_status", 32'(bus.status), 32'd1);

    // writes while running must be dropped (entry 9 and fail slot 1 used by vectors 7/8)
    cfg_write(4'd9, 2'd1, 12'd20, 12'd0, 12'd0);
    fail_write(2'd1, 12'd5);

    for (int i = 0; i < NV; i++) begin
      bus.retire = vec[i].retire; bus.pc_x = vec[i].pc_x; bus.pc_f = vec[i].pc_f;
      bus.cont_pe = vec[i].cont_pe; bus.cont_addr = vec[i].cont_addr;
      sb_q.push_back(vec[i]);
      tick();
      bus.retire = 1'b0;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_redirect", i), 32'(bus.redirect_valid), 32'(e.rv));
      if (e.rv) chk($sformatf("v%0d_raddr", i), 32'(bus.redirect_addr), 32'(e.raddr));
      chk($sformatf("v%0d_pass", i), 32'(bus.pass_valid), 32'(e.pv));
      if (e.pv) chk($sformatf("v%0d_pidx", i), 32'(bus.pass_idx), 32'(e.pidx));
      chk($sformatf("v%0d_hits", i), 32'(bus.hits), 32'(e.hits));
      chk($sformatf("v%0d_count", i), 32'(bus.pass_count), 32'(e.cnt));
      chk($sformatf("v%0d_status", i), 32'(bus.status), 32'(e.st));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(e.st >= 3'd2));
    end

    // re-arm from PASS after a table write in the terminal state
    cfg_write(4'd3, 2'd1, 12'd40, 12'd0, 12'd0);
    pulse_start();
    chk("rearm_status", 32'(bus.status), 32'd1);
    chk("rearm_done", 32'(bus.done), 32'd0);
    chk("rearm_hits", 32'(bus.hits), 32'd0);
    chk("rearm_count", 32'(bus.pass_count), 32'd0);
    do_retire(12'd9, 12'd9, 1'b1, 12'd40);
    chk("e3_pass", 32'(bus.pass_valid), 32'd1);
    chk("e3_pidx", 32'(bus.pass_idx), 32'd3);
    chk("e3_count", 32'(bus.pass_count), 32'd1);
    do_retire(12'd9, 12'd9, 1'b1, 12'd12);
    chk("kept_pidx", 32'(bus.pass_idx), 32'd2);
    chk("kept_hits", 32'(bus.hits), 32'h2c);
    chk("kept_count", 32'(bus.pass_count), 32'd3);
    do_retire(12'd0, 12'd1, 1'b0, 12'd0);
    chk("kept_skip", 32'(bus.redirect_valid), 32'd1);
    chk("kept_skip_addr", 32'(bus.redirect_addr), 32'd8);

    // fail beats end on the same label; terminal state ignores later retires
    do_retire(12'd1666, 12'd0, 1'b0, 12'd0);
    chk("fail_status", 32'(bus.status), 32'd3);
    chk("fail_done", 32'(bus.done), 32'd1);
    do_retire(12'd1564, 12'd0, 1'b0, 12'd0);
    chk("fail_hold", 32'(bus.status), 32'd3);
    do_retire(12'd0, 12'd1, 1'b0, 12'd0);
    chk("fail_no_redirect", 32'(bus.redirect_valid), 32'd0);

    // watchdog
    bus.limit = 32'd100;
    pulse_start();
    chk("wd_start", 32'(bus.status), 32'd1);
`ifdef UCODE_MON_WATCHDOG_EN
    n = 0;
    while (n < 200 && bus.status != 3'd4) begin
      tick();
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd100);
    chk("wd_done", 32'(bus.done), 32'd1);
    bus.limit = 32'd0;
    pulse_start();
    repeat (10000) tick();
    chk("wd_off_status", 32'(bus.status), 32'd1);
`else
    n = 0;
    repeat (150) begin
      tick();
      n++;
    end
    chk("wd_absent_status", 32'(bus.status), 32'd1);
`endif

    // reset in RUN with a pass pending
    do_retire(12'd0, 12'd1, 1'b1, 12'd12);
    chk("pre_rst_pass", 32'(bus.pass_valid), 32'd1);
    bus.retire = 1'b1; bus.pc_x = 12'd0; bus.pc_f = 12'd1; bus.cont_pe = 1'b1; bus.cont_addr = 12'd30;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.retire = 1'b0;
    chk("mid_rst_status", 32'(bus.status), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_pass", 32'(bus.pass_valid), 32'd0);
    chk("mid_rst_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("mid_rst_raddr", 32'(bus.redirect_addr), 32'd0);
    chk("mid_rst_pidx", 32'(bus.pass_idx), 32'd0);
    chk("mid_rst_hits", 32'(bus.hits), 32'd0);
    chk("mid_rst_count", 32'(bus.pass_count), 32'd0);
    bus.limit = 32'd0;
    pulse_start();
    do_retire(12'd0, 12'd1, 1'b1, 12'd12);
    chk("cleared_pass", 32'(bus.pass_valid), 32'd0);
    chk("cleared_skip", 32'(bus.redirect_valid), 32'd0);
    chk("cleared_hits", 32'(bus.hits), 32'd0);
    do_retire(12'd1666, 12'd0, 1'b0, 12'd0);
    chk("cleared_fail", 32'(bus.status), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucode_checkpoint_monitor.md
# ucode_checkpoint_monitor

Parametrised checkpoint monitor for microcode self-test runs. It watches retired microinstructions and does four things: reports pass checkpoints (CONT/PE to a label), redirects execution when a from→to transition matches a skip entry, detects fail labels, and enforces a cycle watchdog. It sits beside `cpu` in simulation and FPGA bring-up builds. It replaces hand-coded per-test label checks with a loadable table of ENTRIES checkpoints.

## Interface
- `PC_W`, 12, microaddress width
- `ENTRIES`, 16, checkpoint table depth
- `FAILS`, 4, fail-label slots
- `CNT_W`, 16, pass counter width
- `LIMIT_W`, 32, watchdog counter width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; one clock, all state in this domain
- `start`  in  1  arm/re-arm pulse
- `cfg_we`  in  1  table write strobe
- `cfg_idx`  in  $clog2(ENTRIES)  table entry index
- `cfg_kind`  in  2  0=off, 1=pass, 2=skip, 3=end
- `cfg_from`, `cfg_to`, `cfg_target`  in  PC_W each  entry fields
- `fail_we`  in  1  fail slot write strobe
- `fail_idx`  in  $clog2(FAILS)  fail slot index
- `fail_addr`  in  PC_W  fail label
- `retire`  in  1  instruction-retired strobe
- `pc_x`  in  PC_W  address of the retiring instruction
- `pc_f`  in  PC_W  next fetch address
- `cont_pe`  in  1  retiring opcode is CONT with map=PE
- `cont_addr`  in  PC_W  CONT target field
- `limit`  in  LIMIT_W  watchdog cycles; 0 disables the watchdog
- `redirect_valid`  out  1  one-cycle jump request
- `redirect_addr`  out  PC_W  jump target
- `pass_valid`  out  1  one-cycle first-hit pulse
- `pass_idx`  out  $clog2(ENTRIES)  entry that hit
- `hits`  out  ENTRIES  sticky per-entry hit bitmap
- `pass_count`  out  CNT_W  distinct pass entries hit, saturating
- `status`  out  3  0=IDLE, 1=RUN, 2=PASS, 3=FAIL, 4=TIMEOUT
- `done`  out  1  status ∈ {PASS, FAIL, TIMEOUT}

## Operation
- Reset: state IDLE; all entry kinds off; fail slots invalid; hits, pass_count and watchdog cleared; all outputs 0.
- `cfg_we` / `fail_we` take effect only in IDLE or a terminal state. They are ignored in RUN. A `fail_we` write marks the slot valid.
- `start` in IDLE or a terminal state: go to RUN; clear hits, pass_count and watchdog; keep the table. `start` in RUN is ignored.
- In RUN, on `retire`, one event is selected in this priority order:
  1. pc_x equals any valid fail slot → FAIL.
  2. An end entry with pc_x==from → PASS.
  3. A skip entry with pc_x==from and pc_f==to → redirect_valid=1, redirect_addr=target. The lowest matching index wins.
  4. Pass entries with cont_pe and cont_addr==from → set the hit bit of every matching entry. Among newly hit entries, pulse pass_valid with the lowest index. pass_count increases by the number of newly set bits and saturates at all-ones. Entries already hit produce no pulse and no count.
- Pass processing (step 4) also runs alongside step 3 on the same retire. A redirect and a pass can coexist.
- Redirect lockout: a `retire` in the cycle right after redirect_valid skips skip-entry evaluation. This keeps a stale pc_f from retriggering.
- No retire: nothing changes except the watchdog.
- Terminal states hold until `start` or `reset`. `retire` is ignored in terminal states.

## Timing
- All outputs are registered. Events appear one cycle after the `retire` sample.
- redirect_valid and pass_valid are single-cycle pulses. The consumer must act in that cycle; there is no back-pressure.
- status and done change in the cycle after the triggering retire.
- Watchdog: counts every clk in RUN, starting at 0 after `start`. When count == limit-1 and limit≠0, it goes to TIMEOUT on the next edge. A FAIL or PASS event in that same cycle takes precedence.
- `reset` during RUN aborts immediately and also clears the table.

## Configuration
- `UCODE_MON_WATCHDOG_EN` defined: watchdog counter and TIMEOUT are implemented as above.
- Not defined: no counter is synthesised; `limit` is ignored; status never reaches 4.

## Test plan
- **Skip redirect:** load entry0 = skip, from=0, to=1, target=8. Start, then retire pc_x=0, pc_f=1 → next cycle redirect_valid=1, redirect_addr=8. Retire again next cycle with the same values → no redirect (lockout).
- **Pass dedup:** entries 2 and 5 = pass, from=12. Retire cont_pe=1, cont_addr=12 → pass_valid, pass_idx=2, hits=0x24, pass_count=2. Repeat the retire → no pulse, count stays 2.
- **Fail priority:** fail slot0=1666, end entry from=1666. Retire pc_x=1666 → status=3, done=1. Later retires change nothing.
- **End/re-arm:** end entry from=1564. Retire pc_x=1564 → status=2. Write entry3 while in PASS → accepted. Pulse `start` → status=1, hits=0, pass_count=0, table preserved.
- **Watchdog (macro on):** limit=100, start, no retires → status=4 exactly 100 cycles after start. With limit=0, status stays 1 for 10000 cycles.
- **Reset mid-run:** assert reset in RUN with a pending pass → next cycle all outputs 0, status=0, and entry kinds read back as off (a pass retire after start produces no pulse).
